// File: rtl/aq_axi_sdma64_pkg.sv
// Shared definitions for the SDMA64 AXI data movers: FSM encoding, AXI constants
// and the 65-bit FIFO word layout.
package aq_axi_sdma64_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CALC = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    localparam logic [2:0] SIZE_64    = 3'b011;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int unsigned LAST_BIT = 64;
    localparam int unsigned BLEN_W   = 9;
    localparam int unsigned CNT_W    = 13;

endpackage

// File: rtl/aq_axi_sdma64_blen_calc.sv
// Burst length for the next AXI burst: min(BURST_MAX, remaining beats,
// beats left before the next 4 KB boundary).
module aq_axi_sdma64_blen_calc
    import aq_axi_sdma64_pkg::*;
#(
    parameter int unsigned BURST_MAX = 16
) (
    input  logic [31:0]       remaining,
    input  logic [8:0]        addr_beat,
    output logic [BLEN_W-1:0] blen_c
);

    logic [9:0] to_boundary;
    logic [9:0] cap_rem;

    // 10-bit span so an aligned address yields a full 512-beat page
    assign to_boundary = 10'd512 - 10'(addr_beat);

    always_comb begin
        cap_rem = (remaining < 32'(BURST_MAX)) ? remaining[9:0] : 10'(BURST_MAX);
        blen_c  = BLEN_W'((to_boundary < cap_rem) ? to_boundary : cap_rem);
    end

endmodule

// File: rtl/aq_axi_sdma64_wdrain.sv
// S2MM drain: pops the 65-bit FWFT FIFO and writes one command's data to memory
// as a sequence of single-outstanding AXI4 INCR bursts.
module aq_axi_sdma64_wdrain
    import aq_axi_sdma64_pkg::*;
#(
    parameter int unsigned BURST_MAX = 16,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [31:0]       CMD_LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic              FIFO_RDEN,
    input  logic [64:0]       FIFO_DO,
    input  logic              FIFO_EMPTY,
    input  logic [CNT_W-1:0]  FIFO_RDCOUNT,
    output logic [ADDR_W-1:0] M_AWADDR,
    output logic [7:0]        M_AWLEN,
    output logic [2:0]        M_AWSIZE,
    output logic [1:0]        M_AWBURST,
    output logic              M_AWVALID,
    input  logic              M_AWREADY,
    output logic [63:0]       M_WDATA,
    output logic [7:0]        M_WSTRB,
    output logic              M_WLAST,
    output logic              M_WVALID,
    input  logic              M_WREADY,
    input  logic [1:0]        M_BRESP,
    input  logic              M_BVALID,
    output logic              M_BREADY
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       rem_q, rem_d;
    logic [7:0]        beat_q, beat_d;
    logic [7:0]        awlen_q, awlen_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [BLEN_W-1:0] blen_c;
    logic [31:0]       cur_blen;
    logic              w_hs;
    logic              final_beat;

    aq_axi_sdma64_blen_calc #(
        .BURST_MAX (BURST_MAX)
    ) u_blen (
        .remaining (rem_q),
        .addr_beat (addr_q[11:3]),
        .blen_c    (blen_c)
    );

    assign CMD_READY = (state_q == ST_IDLE);
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign M_AWADDR  = addr_q;
    assign M_AWLEN   = awlen_q;
    assign M_AWSIZE  = SIZE_64;
    assign M_AWBURST = BURST_INCR;
    assign M_AWVALID = (state_q == ST_ADDR);
    assign M_WDATA   = FIFO_DO[63:0];
    assign M_WSTRB   = 8'hFF;
    assign M_WVALID  = (state_q == ST_DATA) && !FIFO_EMPTY;
    assign M_WLAST   = (state_q == ST_DATA) && (beat_q == awlen_q);
    assign M_BREADY  = (state_q == ST_RESP);
    assign FIFO_RDEN = w_hs;

    assign w_hs       = M_WVALID && M_WREADY;
    assign cur_blen   = 32'(awlen_q) + 32'd1;
    // the head word must carry the end flag exactly on the command's last beat
    assign final_beat = M_WLAST && (rem_q == cur_blen);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            awlen_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            awlen_q <= awlen_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        beat_d  = beat_q;
        awlen_d = awlen_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    addr_d = CMD_ADDR & ~ADDR_W'(7);
                    rem_d  = CMD_LEN;
                    err_d  = 1'b0;
                    if (CMD_LEN == 32'd0) done_d  = 1'b1;
                    else                  state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                awlen_d = 8'(blen_c - BLEN_W'(1));
                beat_d  = '0;
                // hold off AW until the whole burst is already in the FIFO
                if (CNT_W'(blen_c) <= FIFO_RDCOUNT) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (M_AWREADY) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (w_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (FIFO_DO[LAST_BIT] != final_beat) err_d = 1'b1;
                    if (M_WLAST) begin
                        addr_d  = addr_q + ADDR_W'(cur_blen << 3);
                        rem_d   = rem_q - cur_blen;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (M_BVALID) begin
                    if (M_BRESP != RESP_OKAY) err_d = 1'b1;
                    if (rem_q != 32'd0) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_aq_axi_sdma64_wdrain.sv
// Randomised bench for aq_axi_sdma64_wdrain against a transaction-level model
// of the command -> bursts -> beats -> response flow.
module tb_aq_axi_sdma64_wdrain;

    localparam int unsigned BURST_MAX = 16;
    localparam int unsigned ADDR_W    = 32;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [31:0] CMD_ADDR = '0;
    logic [31:0] CMD_LEN = '0;
    logic        BUSY, DONE, ERR, FIFO_RDEN;
    logic [64:0] FIFO_DO = '0;
    logic        FIFO_EMPTY = 1'b1;
    logic [12:0] FIFO_RDCOUNT = '0;
    logic [31:0] M_AWADDR;
    logic [7:0]  M_AWLEN;
    logic [2:0]  M_AWSIZE;
    logic [1:0]  M_AWBURST;
    logic        M_AWVALID;
    logic        M_AWREADY = 1'b0;
    logic [63:0] M_WDATA;
    logic [7:0]  M_WSTRB;
    logic        M_WLAST, M_WVALID;
    logic        M_WREADY = 1'b0;
    logic [1:0]  M_BRESP = '0;
    logic        M_BVALID = 1'b0;
    logic        M_BREADY;

    aq_axi_sdma64_wdrain #(.BURST_MAX(BURST_MAX), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .FIFO_RDEN(FIFO_RDEN), .FIFO_DO(FIFO_DO), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_RDCOUNT(FIFO_RDCOUNT), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN),
        .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID),
        .M_AWREADY(M_AWREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY), .M_BRESP(M_BRESP),
        .M_BVALID(M_BVALID), .M_BREADY(M_BREADY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    // test FIFO contents and expected streams
    logic [64:0] fq[$];
    logic [63:0] exp_w[$];
    burst_t      exp_aw[$];
    logic [31:0] obs_addr[$];
    logic [7:0]  obs_len[$];
    logic [64:0] tmp_word;

    bit active, in_w, b_phase, done_exp, err_m;
    bit prev_awv, prev_cnt_ok, prev_wait;
    bit w_hs, b_hs, aw_hs, acc, awaiting, cnt_ok, done_n, err_n;
    int cur_len, beat, cmd_left, bcount, cmd_pops, w_beats, done_cnt;
    int bad_burst = -1;
    int rd_cap = 8191;
    int p_aw = 100, p_w = 100, p_b = 100, p_stall = 0;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // split a command into 4 KB-safe bursts of at most BURST_MAX beats
    function automatic void plan(input logic [31:0] a0, input int unsigned len);
        logic [31:0] a;
        int unsigned r, b, room;
        burst_t bt;
        a = a0 & ~32'h7;
        r = len;
        exp_aw.delete();
        while (r > 0) begin
            b = (r < BURST_MAX) ? r : BURST_MAX;
            room = (4096 - (a % 4096)) / 8;
            if (room < b) b = room;
            bt.addr = a;
            bt.len  = 8'(b - 1);
            exp_aw.push_back(bt);
            a = a + 32'(b * 8);
            r = r - b;
        end
    endfunction

    // responder / FIFO front end, updated on the falling edge
    always @(negedge CLK) begin
        int sz;
        sz = fq.size();
        M_AWREADY    = ($urandom_range(0, 99) < p_aw);
        M_WREADY     = ($urandom_range(0, 99) < p_w);
        M_BVALID     = b_phase && ($urandom_range(0, 99) < p_b);
        M_BRESP      = (bcount == bad_burst) ? 2'b10 : 2'b00;
        FIFO_EMPTY   = (sz == 0) || ($urandom_range(0, 99) < p_stall);
        FIFO_DO      = (sz > 0) ? fq[0] : {1'b1, 64'hBAD0_BAD0_BAD0_BAD0};
        FIFO_RDCOUNT = 13'((sz < rd_cap) ? sz : rd_cap);
    end

    // compare process: checks outputs every cycle, then advances the model
    always @(negedge CLK) begin
        #2;
        if (RST) begin
            if (FIFO_RDEN && fq.size() > 0) tmp_word = fq.pop_front();
            exp_aw.delete();
            active = 0; in_w = 0; b_phase = 0; done_exp = 0; err_m = 0;
            prev_awv = 0; prev_cnt_ok = 0; prev_wait = 0;
        end else begin
            w_hs  = M_WVALID && M_WREADY;
            b_hs  = M_BVALID && M_BREADY;
            aw_hs = M_AWVALID && M_AWREADY;
            acc   = CMD_VALID && CMD_READY;
            awaiting = active && !in_w && !b_phase && (exp_aw.size() > 0);
            cnt_ok   = awaiting && (int'(FIFO_RDCOUNT) > int'(exp_aw[0].len));

            chk("cmd_ready", 64'(CMD_READY), 64'(!active));
            chk("busy", 64'(BUSY), 64'(active));
            chk("done", 64'(DONE), 64'(done_exp));
            chk("err", 64'(ERR), 64'(err_m));
            chk("wvalid", 64'(M_WVALID), 64'(in_w && !FIFO_EMPTY));
            chk("rden", 64'(FIFO_RDEN), 64'(w_hs));
            chk("wlast", 64'(M_WLAST), 64'(in_w && (beat == cur_len)));
            chk("bready", 64'(M_BREADY), 64'(b_phase));
            if (!awaiting) chk("aw_idle", 64'(M_AWVALID), 64'd0);
            if (!prev_awv && !prev_cnt_ok) chk("aw_gate", 64'(M_AWVALID), 64'd0);
            if (awaiting && prev_wait) chk("aw_latency", 64'(M_AWVALID), 64'd1);

            done_n = 0;
            err_n  = err_m;
            if (aw_hs && exp_aw.size() > 0) begin
                chk("awaddr", 64'(M_AWADDR), 64'(exp_aw[0].addr));
                chk("awlen", 64'(M_AWLEN), 64'(exp_aw[0].len));
                chk("awsize", 64'(M_AWSIZE), 64'(3'b011));
                chk("awburst", 64'(M_AWBURST), 64'(2'b01));
                obs_addr.push_back(M_AWADDR);
                obs_len.push_back(M_AWLEN);
                cur_len = int'(exp_aw[0].len);
                beat = 0;
                in_w = 1;
                tmp_word = 65'(exp_aw.pop_front());
            end
            if (w_hs) begin
                if (exp_w.size() > 0) begin
                    chk("wdata", M_WDATA, exp_w[0]);
                    tmp_word = 65'(exp_w.pop_front());
                end
                chk("wstrb", 64'(M_WSTRB), 64'hFF);
                if (FIFO_DO[64] != (cmd_left == 1)) err_n = 1;
                if (beat == cur_len) begin
                    in_w = 0;
                    b_phase = 1;
                end
                beat++; cmd_left--; cmd_pops++; w_beats++;
            end
            if (FIFO_RDEN && fq.size() > 0) tmp_word = fq.pop_front();
            if (b_hs) begin
                if (M_BRESP != 2'b00) err_n = 1;
                bcount++;
                b_phase = 0;
                if (exp_aw.size() == 0 && cmd_left == 0) begin
                    active = 0;
                    done_n = 1;
                end
            end
            if (acc) begin
                plan(CMD_ADDR, CMD_LEN);
                err_n = 0;
                cmd_left = int'(CMD_LEN);
                bcount = 0; cmd_pops = 0; w_beats = 0;
                obs_addr.delete();
                obs_len.delete();
                if (CMD_LEN == 0) done_n = 1;
                else active = 1;
            end
            if (DONE) done_cnt++;
            prev_wait   = awaiting && !M_AWVALID && cnt_ok;
            prev_awv    = M_AWVALID;
            prev_cnt_ok = cnt_ok;
            done_exp    = done_n;
            err_m       = err_n;
        end
    end

    task automatic push_words(input int n, input int flag_at);
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            fq.push_back({(i == flag_at) ? 1'b1 : 1'b0, d});
            exp_w.push_back(d);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] len, output int target);
        int n;
        n = 0;
        @(negedge CLK);
        while (!CMD_READY && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        target = done_cnt + 1;
        CMD_VALID = 1'b1;
        CMD_ADDR  = a;
        CMD_LEN   = len;
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        #3;
        chk("done_reached", 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic set_rand(input int aw, input int w, input int b, input int st);
        p_aw = aw; p_w = w; p_b = b; p_stall = st;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt, n, len;
        logic [31:0] a;

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #3;
        chk("rst_cmd_ready", 64'(CMD_READY), 64'd1);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);
        chk("rst_awvalid", 64'(M_AWVALID), 64'd0);
        chk("rst_wlast", 64'(M_WLAST), 64'd0);
        chk("rst_awaddr", 64'(M_AWADDR), 64'd0);
        chk("rst_awlen", 64'(M_AWLEN), 64'd0);

        // single aligned burst
        push_words(16, 15);
        issue(32'h1000, 32'd16, tgt);
        wait_done(tgt);
        chk("single_naw", 64'(obs_addr.size()), 64'd1);
        chk("single_addr", 64'(obs_addr[0]), 64'h1000);
        chk("single_len", 64'(obs_len[0]), 64'd15);
        chk("single_pops", 64'(cmd_pops), 64'd16);
        chk("single_err", 64'(ERR), 64'd0);

        // 4 KB boundary split under random backpressure
        set_rand(60, 60, 50, 0);
        push_words(32, 31);
        issue(32'h1FC0, 32'd32, tgt);
        wait_done(tgt);
        chk("split_naw", 64'(obs_addr.size()), 64'd3);
        chk("split_a0", 64'(obs_addr[0]), 64'h1FC0);
        chk("split_l0", 64'(obs_len[0]), 64'd7);
        chk("split_a1", 64'(obs_addr[1]), 64'h2000);
        chk("split_l1", 64'(obs_len[1]), 64'd15);
        chk("split_a2", 64'(obs_addr[2]), 64'h2080);
        chk("split_l2", 64'(obs_len[2]), 64'd7);
        chk("split_pops", 64'(cmd_pops), 64'd32);

        // FIFO occupancy gating
        set_rand(100, 100, 100, 0);
        rd_cap = 10;
        push_words(16, 15);
        issue(32'h0, 32'd16, tgt);
        repeat (20) @(negedge CLK);
        #3;
        chk("gate_naw", 64'(obs_addr.size()), 64'd0);
        chk("gate_awvalid", 64'(M_AWVALID), 64'd0);
        rd_cap = 8191;
        wait_done(tgt);
        chk("gate_pops", 64'(cmd_pops), 64'd16);

        // random commands with W backpressure and FIFO empty pulses
        set_rand(70, 50, 60, 25);
        for (int k = 0; k < 6; k++) begin
            a   = 32'($urandom_range(0, 16383) << 3) | 32'($urandom_range(0, 7));
            len = $urandom_range(1, 60);
            push_words(len, len - 1);
            issue(a, 32'(len), tgt);
            wait_done(tgt);
            chk("rand_pops", 64'(cmd_pops), 64'(len));
        end

        // error response on the second burst
        set_rand(80, 80, 80, 10);
        bad_burst = 1;
        push_words(48, 47);
        issue(32'h0, 32'd48, tgt);
        wait_done(tgt);
        bad_burst = -1;
        chk("bresp_err", 64'(ERR), 64'd1);
        push_words(4, 3);
        issue(32'h800, 32'd4, tgt);
        wait_done(tgt);
        chk("err_cleared", 64'(ERR), 64'd0);

        // end flag on beat 5 of 8
        push_words(8, 4);
        issue(32'h3000, 32'd8, tgt);
        wait_done(tgt);
        chk("flag_err", 64'(ERR), 64'd1);

        // zero-length command
        n = done_cnt;
        issue(32'h40, 32'd0, tgt);
        wait_done(tgt);
        chk("len0_naw", 64'(obs_addr.size()), 64'd0);
        chk("len0_done", 64'(done_cnt - n), 64'd1);

        // reset while streaming data
        set_rand(100, 100, 100, 0);
        push_words(8, 7);
        issue(32'h4000, 32'd8, tgt);
        n = 0;
        while (w_beats < 3 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #3;
        chk("rstmid_awvalid", 64'(M_AWVALID), 64'd0);
        chk("rstmid_wvalid", 64'(M_WVALID), 64'd0);
        chk("rstmid_bready", 64'(M_BREADY), 64'd0);
        chk("rstmid_rden", 64'(FIFO_RDEN), 64'd0);
        chk("rstmid_busy", 64'(BUSY), 64'd0);
        chk("rstmid_cmd_ready", 64'(CMD_READY), 64'd1);
        fq.delete();
        exp_w.delete();
        repeat (5) @(negedge CLK);

        // recovery after reset
        push_words(5, 4);
        issue(32'h5008, 32'd5, tgt);
        wait_done(tgt);
        chk("post_rst_pops", 64'(cmd_pops), 64'd5);
        chk("post_rst_err", 64'(ERR), 64'd0);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
